led_fader: RTL and testbench
============================

Name: led_fader

Overview:
- Downstream of the LED blink stage: consumes its square-wave blink output and drives the physical LED with a PWM signal.
- The LED fades in and out smoothly ("breathing") instead of switching hard.
- A 4-state FSM ramps a duty register up while the blink input is high and down while it is low.
- A PWM generator converts the duty value into the LED waveform.

Parameters:
- PwmWidth, 8, width of the duty register and the PWM counter; PWM period is 2^PwmWidth-1 cycles.
- StepDiv, 16, clock cycles per duty step (must be >= 1); full ramp time is (2^PwmWidth-1)*StepDiv cycles.

Ports:
- clk_i  input  1  rising-edge clock
- rst_ni  input  1  reset, asynchronous, active-low
- en_i  input  1  enable; low forces LED off and freezes ramp/prescaler
- blink_i  input  1  blink level from the upstream blink stage
- led_o  output  1  PWM LED drive
- duty_o  output  PwmWidth  current working duty value
- busy_o  output  1  high while in RAMP_UP or RAMP_DOWN

Behaviour:
- Reset values:
  - led_o=0, duty_o=0, busy_o=0.
  - FSM=OFF; prescaler=0; PWM counter=0; shadow duty=0; blink register=0.
- blink_i is registered once (blink_q). All FSM decisions use blink_q, so there is 1 cycle of input latency.
- Prescaler:
  - Counts 0..StepDiv-1 while en_i=1 and FSM is in RAMP_UP or RAMP_DOWN.
  - step_tick is asserted on the cycle it equals StepDiv-1; it then wraps to 0.
  - Held at 0 in OFF/ON. Holds its value while en_i=0.
- FSM states and transitions (evaluated only when en_i=1):
  - OFF: duty=0. blink_q=1 -> RAMP_UP.
  - RAMP_UP: on step_tick, duty += 1.
    - If duty reaches Max (all ones) -> ON.
    - If blink_q=0 -> RAMP_DOWN immediately; duty is kept (no jump).
  - ON: duty=Max. blink_q=0 -> RAMP_DOWN.
  - RAMP_DOWN: on step_tick, duty -= 1.
    - If duty reaches 0 -> OFF.
    - If blink_q=1 -> RAMP_UP immediately.
  - Direction reversal resets the prescaler to 0.
- Simultaneous events: if step_tick and a blink_q change occur in the same cycle, the step is applied in the old direction, then the state changes.
- Duty arithmetic saturates: never wraps past Max or below 0.
- PWM generator:
  - Counter runs 0..Max-1 and wraps to 0; period is Max cycles.
  - Shadow duty is loaded from the working duty only on the cycle the counter is 0, giving glitch-free updates.
  - led_o is registered: led_o <= en_i & (pwm_cnt < shadow_duty).
  - duty=0 gives a constant 0; duty=Max gives a constant 1.
- en_i=0:
  - led_o goes to 0 on the next cycle.
  - FSM, duty and prescaler are frozen; the PWM counter keeps running.
  - When en_i returns to 1, operation resumes from the frozen duty.
- busy_o is registered and equals (state is RAMP_UP or RAMP_DOWN).
- duty_o equals the working duty register.
- Reset mid-ramp: all state returns to reset values immediately (asynchronous). LED off.

Decomposition:
- Package led_fader_pkg:
  - Default PwmWidth and StepDiv constants.
  - Enum fade_state_e {OFF, RAMP_UP, ON, RAMP_DOWN}.
- Sub-module pwm_gen (parameter PwmWidth):
  - Inputs: clk_i, rst_ni, en_i, duty_i.
  - Output: pwm_o.
  - Contains the PWM counter, shadow register and compare.
- Top-level led_fader holds the input register, prescaler, FSM and duty register.

Test Plan:
All scenarios use PwmWidth=4 (Max=15), StepDiv=2.
- Reset then blink_i=0, en_i=1 for 100 cycles -> led_o, duty_o, busy_o stay 0; FSM stays OFF.
- blink_i rises and is held -> busy_o=1 from cycle 2; duty increments every 2 cycles; duty_o=15 and busy_o=0 after 30 cycles of ramp; led_o then constantly 1.
- Reach ON, then drop blink_i -> duty decrements 15->0 over 30 cycles, FSM returns to OFF, led_o=0.
- Hold duty at 5 by dropping en_i mid-ramp -> led_o=0 the next cycle and duty_o stays 5. Raise en_i -> ramp continues 5->6 after 2 cycles.
  - Separately, hold duty at 5 with a 5/15 pattern and confirm led_o is high 5 of every 15 cycles, aligned to PWM-counter wrap.
- Toggle blink_i low when duty_o=7 during RAMP_UP -> next step gives duty 6. No value jump, no wrap below 0 or above 15.
- Assert rst_ni=0 asynchronously mid-ramp at duty 9 -> all outputs 0 within the same cycle; after release the FSM restarts from OFF.

Source files
------------

// File: rtl/led_fader_pkg.sv
// Shared constants and FSM state encoding for the LED breathing fader.
package led_fader_pkg;

  localparam int unsigned PwmWidthDef = 8;
  localparam int unsigned StepDivDef  = 16;

  typedef enum logic [1:0] {
    OFF       = 2'd0,
    RAMP_UP   = 2'd1,
    ON        = 2'd2,
    RAMP_DOWN = 2'd3
  } fade_state_e;

endpackage

// File: rtl/led_fader_pwm_gen.sv
// PWM generator: free-running counter with period 2^PwmWidth-1 and a shadowed
// duty that only changes at counter wrap, so pulses are never truncated.
module pwm_gen #(
  parameter int unsigned PwmWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic [PwmWidth-1:0] duty_i,
  output logic                pwm_o
);

  localparam logic [PwmWidth-1:0] CntLast = PwmWidth'((1 << PwmWidth) - 2);

  logic [PwmWidth-1:0] cnt;
  logic [PwmWidth-1:0] shadow;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt    <= '0;
      shadow <= '0;
      pwm_o  <= 1'b0;
    end else begin
      cnt <= (cnt == CntLast) ? '0 : cnt + PwmWidth'(1);
      if (cnt == '0) begin
        shadow <= duty_i;
      end
      pwm_o <= en_i & (cnt < shadow);
    end
  end

endmodule

// File: rtl/led_fader.sv
// Breathing LED driver: ramps a duty value up while blink is high and down
// while it is low, one step per StepDiv cycles, and PWMs the LED from it.
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned PwmWidth = PwmWidthDef,
  parameter int unsigned StepDiv  = StepDivDef
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                blink_i,
  output logic                led_o,
  output logic [PwmWidth-1:0] duty_o,
  output logic                busy_o
);

  localparam int unsigned PresW = (StepDiv > 1) ? $clog2(StepDiv) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(StepDiv - 1);
  localparam logic [PwmWidth-1:0] DutyMax = '1;

  fade_state_e         state, state_n;
  logic [PwmWidth-1:0] duty, duty_n;
  logic [PresW-1:0]    presc, presc_n;
  logic                blink_q;
  logic                busy_q;
  logic                ramping;
  logic                step_tick;

  assign ramping   = (state == RAMP_UP) || (state == RAMP_DOWN);
  assign step_tick = ramping && (presc == PresLast);

  // A step due this cycle is applied in the current direction first; any
  // reversal then takes effect and restarts the prescaler.
  always_comb begin
    state_n = state;
    duty_n  = duty;
    presc_n = presc;
    if (en_i) begin
      unique case (state)
        OFF: begin
          duty_n  = '0;
          presc_n = '0;
          if (blink_q) begin
            state_n = RAMP_UP;
          end
        end
        RAMP_UP: begin
          presc_n = step_tick ? '0 : presc + PresW'(1);
          if (step_tick && (duty != DutyMax)) begin
            duty_n = duty + PwmWidth'(1);
          end
          if (!blink_q) begin
            state_n = RAMP_DOWN;
            presc_n = '0;
          end else if (duty_n == DutyMax) begin
            state_n = ON;
            presc_n = '0;
          end
        end
        ON: begin
          duty_n  = DutyMax;
          presc_n = '0;
          if (!blink_q) begin
            state_n = RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          presc_n = step_tick ? '0 : presc + PresW'(1);
          if (step_tick && (duty != '0)) begin
            duty_n = duty - PwmWidth'(1);
          end
          if (blink_q) begin
            state_n = RAMP_UP;
            presc_n = '0;
          end else if (duty_n == '0) begin
            state_n = OFF;
            presc_n = '0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= OFF;
      duty    <= '0;
      presc   <= '0;
      blink_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      duty    <= duty_n;
      presc   <= presc_n;
      blink_q <= blink_i;
      busy_q  <= (state_n == RAMP_UP) || (state_n == RAMP_DOWN);
    end
  end

  pwm_gen #(
    .PwmWidth(PwmWidth)
  ) u_pwm_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_i),
    .duty_i(duty),
    .pwm_o (led_o)
  );

  assign duty_o = duty;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader (PwmWidth=4, StepDiv=2): stimulus queues
// cycle-tagged expectations, a monitor compares them at the falling edge.
module tb_led_fader;

  localparam int SigLed  = 0;
  localparam int SigDuty = 1;
  localparam int SigBusy = 2;
  localparam int SigRef  = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       blink;
  logic       led;
  logic [3:0] duty;
  logic       busy;
  logic       ref_led;

  led_fader #(
    .PwmWidth(4),
    .StepDiv (2)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .blink_i(blink),
    .led_o  (led),
    .duty_o (duty),
    .busy_o (busy)
  );

  // Stand-alone PWM instance with a fixed 5/15 duty to check waveform shape.
  pwm_gen #(
    .PwmWidth(4)
  ) u_ref_pwm (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (1'b1),
    .duty_i(4'd5),
    .pwm_o (ref_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  event mon_ev;

  function automatic int actual(input int sig);
    case (sig)
      SigLed:  return int'(led);
      SigDuty: return int'(duty);
      SigBusy: return int'(busy);
      default: return int'(ref_led);
    endcase
  endfunction

  task automatic expect_at(input string name, input int sig, input int dly, input int val);
    exp_t e;
    e.cyc  = cyc + dly;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    forever begin
      @(negedge clk or mon_ev);
      for (int i = 0; i < sb.size(); ) begin
        if (sb[i].cyc == cyc) begin
          n_tests++;
          if (actual(sb[i].sig) != sb[i].val) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                     sb[i].name, cyc, actual(sb[i].sig), sb[i].val);
          end
          sb.delete(i);
        end else if (sb[i].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d never sampled, got %0d, expected %0d",
                   sb[i].name, sb[i].cyc, actual(sb[i].sig), sb[i].val);
          sb.delete(i);
        end else begin
          i++;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    blink = 1'b0;

    // Reset values, then idle with blink low.
    step(2);
    expect_at("rst_led", SigLed, 0, 0);
    expect_at("rst_duty", SigDuty, 0, 0);
    expect_at("rst_busy", SigBusy, 0, 0);
    step(0);
    rst_n = 1'b1;
    // First edge after release loads the shadow; afterwards high for cnt 0..4.
    for (int n = 2; n < 32; n++) begin
      expect_at("pwm5_pattern", SigRef, n, (((n - 1) % 15) < 5) ? 1 : 0);
    end
    for (int n = 10; n <= 100; n += 10) begin
      expect_at("idle_led", SigLed, n, 0);
      expect_at("idle_duty", SigDuty, n, 0);
      expect_at("idle_busy", SigBusy, n, 0);
    end
    step(100);

    // Full ramp up.
    blink = 1'b1;
    expect_at("up_busy_lat", SigBusy, 1, 0);
    expect_at("up_busy", SigBusy, 2, 1);
    expect_at("up_duty_c3", SigDuty, 3, 0);
    expect_at("up_duty_c4", SigDuty, 4, 1);
    expect_at("up_duty_c5", SigDuty, 5, 1);
    expect_at("up_duty_c6", SigDuty, 6, 2);
    expect_at("up_duty_c31", SigDuty, 31, 14);
    expect_at("up_busy_c31", SigBusy, 31, 1);
    expect_at("up_duty_max", SigDuty, 32, 15);
    expect_at("up_busy_on", SigBusy, 32, 0);
    expect_at("on_duty_hold", SigDuty, 60, 15);
    for (int n = 50; n < 65; n++) expect_at("on_led_const", SigLed, n, 1);
    step(70);

    // Full ramp down.
    blink = 1'b0;
    expect_at("dn_busy", SigBusy, 2, 1);
    expect_at("dn_duty_c2", SigDuty, 2, 15);
    expect_at("dn_duty_c4", SigDuty, 4, 14);
    expect_at("dn_duty_c30", SigDuty, 30, 1);
    expect_at("dn_duty_zero", SigDuty, 32, 0);
    expect_at("dn_busy_off", SigBusy, 32, 0);
    expect_at("off_duty_hold", SigDuty, 60, 0);
    for (int n = 50; n < 65; n++) expect_at("off_led_const", SigLed, n, 0);
    step(70);

    // Freeze at duty 5 with enable low, then resume.
    blink = 1'b1;
    expect_at("frz_duty_pre", SigDuty, 12, 5);
    step(12);
    en = 1'b0;
    expect_at("frz_led_off", SigLed, 1, 0);
    expect_at("frz_duty_c1", SigDuty, 1, 5);
    expect_at("frz_duty_c10", SigDuty, 10, 5);
    expect_at("frz_duty_c20", SigDuty, 20, 5);
    expect_at("frz_busy", SigBusy, 20, 1);
    expect_at("frz_led_c20", SigLed, 20, 0);
    step(20);
    en = 1'b1;
    expect_at("res_duty_c1", SigDuty, 1, 5);
    expect_at("res_duty_c2", SigDuty, 2, 6);
    step(3);

    // Reverse at duty 7 with no step pending: next step goes to 6.
    blink = 1'b0;
    expect_at("rev_duty_c1", SigDuty, 1, 7);
    expect_at("rev_duty_c2", SigDuty, 2, 7);
    expect_at("rev_busy", SigBusy, 2, 1);
    expect_at("rev_duty_c3", SigDuty, 3, 7);
    expect_at("rev_duty_c4", SigDuty, 4, 6);
    expect_at("rev_duty_c14", SigDuty, 14, 1);
    expect_at("rev_duty_zero", SigDuty, 16, 0);
    expect_at("rev_busy_off", SigBusy, 16, 0);
    expect_at("rev_no_wrap", SigDuty, 20, 0);
    step(20);

    // Reversal coinciding with a step: old direction's step lands first.
    blink = 1'b1;
    expect_at("sim_duty_pre", SigDuty, 8, 3);
    step(8);
    blink = 1'b0;
    expect_at("sim_dn_c1", SigDuty, 1, 3);
    expect_at("sim_dn_c2", SigDuty, 2, 4);
    expect_at("sim_dn_busy", SigBusy, 2, 1);
    expect_at("sim_dn_c3", SigDuty, 3, 4);
    expect_at("sim_dn_c4", SigDuty, 4, 3);
    step(4);
    blink = 1'b1;
    expect_at("sim_up_c1", SigDuty, 1, 3);
    expect_at("sim_up_c2", SigDuty, 2, 2);
    expect_at("sim_up_busy", SigBusy, 2, 1);
    expect_at("sim_up_c4", SigDuty, 4, 3);
    expect_at("pre_rst_duty", SigDuty, 16, 9);
    step(16);

    // Asynchronous reset mid-ramp, checked before the next rising edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    expect_at("arst_led", SigLed, 0, 0);
    expect_at("arst_duty", SigDuty, 0, 0);
    expect_at("arst_busy", SigBusy, 0, 0);
    #1;
    ->mon_ev;
    step(2);
    rst_n = 1'b1;
    expect_at("rs_busy_c1", SigBusy, 1, 0);
    expect_at("rs_duty_c1", SigDuty, 1, 0);
    expect_at("rs_busy_c2", SigBusy, 2, 1);
    expect_at("rs_duty_c2", SigDuty, 2, 0);
    expect_at("rs_duty_c4", SigDuty, 4, 1);
    step(6);

    step(2);
    foreach (sb[i]) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: expectation left unchecked, got %0d, expected %0d",
               sb[i].name, actual(sb[i].sig), sb[i].val);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
